// File: rtl/tc_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and the fetch-buffer entry.
// Latency: n/a (types only).
// Backpressure: n/a.
package tc_fetch_pkg;

    // Address width assumed by the fetch-entry struct; the top ADDR_W must match it.
    localparam int FETCH_ADDR_W = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]             instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/tc_fetch_fifo2.sv
// Two-entry fetch buffer with push, pop, flush and occupancy count; head is entry 0.
// Latency: a pushed entry is visible at the head one edge later when the buffer was empty.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush beats push.
module tc_fetch_fifo2
    import tc_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    // Next-state for storage: entries shift toward the head; flush only clears the count
    // so the head keeps presenting its last value while empty.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_dat_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_dat_i;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        ent0_d = ent1_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = push_dat_i;
                    end else begin
                        ent1_d = push_dat_i;
                    end
                    count_d = count_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Storage registers, cleared to zero on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;

endmodule

// File: rtl/tc_fetch_unit.sv
// Instruction fetch: owns the PC, captures 4 ROM bytes per fetch into a 2-entry buffer.
// Latency: ROM data at rom_addr appears on instr one edge later; redirect target two edges after.
// Backpressure: valid/ready toward the decoder; fetch stalls while the buffer is full and not popping.
module tc_fetch_unit
    import tc_fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                STEP     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_b0,
    input  logic [7:0]        rom_b1,
    input  logic [7:0]        rom_b2,
    input  logic [7:0]        rom_b3,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q;
    logic              fetch_en;
    logic              pop;
    logic [1:0]        count;
    fetch_entry_t      push_dat;
    fetch_entry_t      head;

    assign pop         = instr_valid && instr_ready;
    assign instr_valid = (count != 2'd0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign rom_addr    = pc_q;
    assign halted      = halted_q;

    assign push_dat.instr = {rom_b3, rom_b2, rom_b1, rom_b0};
    assign push_dat.pc    = pc_q;

    tc_fetch_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fetch_en),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_o     (head),
        .count_o    (count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: BOOT always advances; RUN/HOLD follow the halt level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = halt ? HOLD : RUN;
            HOLD:    state_d = halt ? HOLD : RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM output: fetch only in RUN, never alongside a redirect, and only with buffer room.
    always_comb begin
        fetch_en = 1'b0;
        if ((state_q == RUN) && !redirect_valid && ((count != 2'd2) || pop)) begin
            fetch_en = 1'b1;
        end
    end

    // PC next value: redirect wins over sequential advance (which wraps naturally).
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fetch_en) begin
            pc_d = pc_q + ADDR_W'(STEP);
        end
    end

    // PC and halted status registers; halted reflects HOLD with an empty buffer one edge late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= (state_q == HOLD) && (count == 2'd0);
        end
    end

endmodule

// File: tb/tb_tc_fetch_unit.sv
module tb_tc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_b0, rom_b1, rom_b2, rom_b3;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic        halted;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: queue of buffered pcs, next pc, mode (0 boot, 1 run, 2 hold).
    logic [15:0] q[$];
    logic [15:0] pc_m;
    int          mode_m;
    logic        halted_m;
    logic [15:0] last_pc;
    logic [31:0] last_instr;

    always #5 clk = ~clk;

    // ROM contents: low address byte xor high address byte (ascending bytes near 0).
    function automatic logic [7:0] rb(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [31:0] exp_instr(input logic [15:0] a);
        return {rb(16'(a + 16'd3)), rb(16'(a + 16'd2)), rb(16'(a + 16'd1)), rb(a)};
    endfunction

    assign rom_b0 = rb(rom_addr);
    assign rom_b1 = rb(16'(rom_addr + 16'd1));
    assign rom_b2 = rb(16'(rom_addr + 16'd2));
    assign rom_b3 = rb(16'(rom_addr + 16'd3));

    tc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_b0         (rom_b0),
        .rom_b1         (rom_b1),
        .rom_b2         (rom_b2),
        .rom_b3         (rom_b3),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pc_m       = 16'h0000;
        mode_m     = 0;
        halted_m   = 1'b0;
        last_pc    = 16'h0000;
        last_instr = 32'h0;
    endtask

    task automatic check_outputs();
        logic [15:0] ep;
        logic [31:0] ei;
        if (q.size() > 0) begin
            ep = q[0];
            ei = exp_instr(q[0]);
        end else begin
            ep = last_pc;
            ei = last_instr;
        end
        chk("rom_addr", 32'(rom_addr), 32'(pc_m));
        chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
        chk("instr_pc", 32'(instr_pc), 32'(ep));
        chk("instr", instr, ei);
        chk("halted", 32'(halted), 32'(halted_m));
        last_pc    = ep;
        last_instr = ei;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model, cross the edge.
    task automatic step(input logic rdy, input logic rv, input logic [15:0] rpc, input logic h);
        int n0;
        int mode0;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        #1;
        check_outputs();
        n0    = q.size();
        mode0 = mode_m;
        halted_m = (mode0 == 2) && (n0 == 0);
        if (n0 > 0 && rdy) void'(q.pop_front());
        if (rv) begin
            q.delete();
            pc_m = rpc;
        end else if (mode0 == 1 && q.size() < 2) begin
            q.push_back(pc_m);
            pc_m = 16'(pc_m + 16'd4);
        end
        mode_m = (mode0 == 0) ? 1 : (h ? 2 : 1);
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check outputs before any clock edge, release after the next edge.
    task automatic do_reset();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic h_lvl;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Startup stream with ready=1.
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_instr", instr, 32'h03020100);
        chk("first_pc", 32'(instr_pc), 32'h0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Backpressure from a fresh start.
        do_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("bp_rom_addr_hold", 32'(rom_addr), 32'h0008);
        chk("bp_head_pc", 32'(instr_pc), 32'h0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Redirect with two buffered entries and a same-cycle pop.
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h0100, 1'b0);
        chk("redir_gap_valid", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("redir_target_pc", 32'(instr_pc), 32'h0100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Wrap around the top of the address space.
        step(1'b1, 1'b1, 16'hFFF8, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Halt with a full buffer, drain, then resume.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("halt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Reset mid-stream with a full buffer, then restart.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Randomized traffic against the model.
        h_lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) h_lvl = ~h_lvl;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 16'($urandom), h_lvl);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
